// File: rtl/path_word_sequencer.sv
// path_word_sequencer: packs a byte stream into 32-bit lane words,
// queues them, and presents each word for a fixed hold window.
module path_word_sequencer #(
  parameter int HOLD_CYCLES = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                               clk_in,
  input  logic                               rst_n,
  input  logic [7:0]                         in_byte,
  input  logic [3:0]                         in_sel,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               run,
  output logic [31:0]                        word_out,
  output logic [3:0]                         path_sel_out,
  output logic                               word_strobe,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES - 1);

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } state_t;

  state_t        r_state;
  logic [1:0]    r_lane;
  logic [23:0]   r_shadow;
  logic [35:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_hold;
  logic [31:0]   r_word;
  logic [3:0]    r_psel;
  logic          r_strobe;
  logic          r_busy;

  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic [35:0]   w_head;

  // Full check uses the registered count, so a same-cycle pop
  // never opens room for a lane-3 push.
  assign in_ready = !(r_lane == 2'd3 && r_count == FULL);
  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && (r_lane == 2'd3);
  assign w_empty  = (r_count == '0);
  assign w_head   = r_mem[r_rptr];

  assign word_out     = r_word;
  assign path_sel_out = r_psel;
  assign word_strobe  = r_strobe;
  assign busy         = r_busy;
  assign fifo_count   = r_count;

  // Pop when idle, or on the last cycle of a hold window.
  always_comb begin
    w_pop = 1'b0;
    unique case (r_state)
      S_IDLE: w_pop = run && !w_empty;
      S_HOLD: w_pop = run && !w_empty && (r_hold == '0);
    endcase
  end

  // Lane pointer and shadow register for lanes 0..2.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_lane   <= 2'd0;
      r_shadow <= '0;
    end else if (w_accept) begin
      r_lane <= r_lane + 2'd1;
      unique case (r_lane)
        2'd0:    r_shadow[7:0]   <= in_byte;
        2'd1:    r_shadow[15:8]  <= in_byte;
        2'd2:    r_shadow[23:16] <= in_byte;
        default: ;
      endcase
    end
  end

  // Word storage; validity is tracked by the pointers alone.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem[r_wptr] <= {in_sel, in_byte, r_shadow};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case (1'b1)
        (w_push && !w_pop): r_count <= r_count + CW'(1);
        (w_pop && !w_push): r_count <= r_count - CW'(1);
        default:            ;
      endcase
    end
  end

  // Presenter FSM with registered word, strobe and busy.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_hold   <= '0;
      r_word   <= '0;
      r_psel   <= '0;
      r_strobe <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (w_pop) begin
        r_word   <= w_head[31:0];
        r_psel   <= w_head[35:32];
        r_strobe <= 1'b1;
        r_hold   <= HOLD_LD;
        r_state  <= S_HOLD;
        r_busy   <= 1'b1;
      end else if (r_state == S_HOLD) begin
        if (r_hold != '0) begin
          r_hold <= r_hold - 8'd1;
        end else begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_path_word_sequencer.sv
// tb_path_word_sequencer: scenario tasks plus a queue-based
// reference model driven by randomized traffic.
module tb_path_word_sequencer;

  localparam int HOLD  = 8;
  localparam int DEPTH = 4;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_byte = '0;
  logic [3:0]  in_sel = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        run = 1'b0;
  logic [31:0] word_out;
  logic [3:0]  path_sel_out;
  logic        word_strobe;
  logic        busy;
  logic [2:0]  fifo_count;

  int n_vec = 0;
  int n_bad = 0;

  path_word_sequencer #(
    .HOLD_CYCLES(HOLD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .in_byte(in_byte),
    .in_sel(in_sel),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .run(run),
    .word_out(word_out),
    .path_sel_out(path_sel_out),
    .word_strobe(word_strobe),
    .busy(busy),
    .fifo_count(fifo_count)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: queue of words, partial-word bytes and
  // the number of cycles left in the current hold window.
  logic [35:0] mq[$];
  int          m_lane = 0;
  logic [7:0]  m_part [3];
  logic [31:0] m_word = '0;
  logic [3:0]  m_sel = '0;
  logic        m_strobe = 1'b0;
  int          m_rem = 0;

  always @(posedge clk_in) begin : model_step
    bit rdy;
    bit pop;
    if (!rst_n) begin
      mq.delete();
      m_lane = 0;
      m_word = '0;
      m_sel = '0;
      m_strobe = 1'b0;
      m_rem = 0;
    end else begin
      rdy = !(m_lane == 3 && mq.size() == DEPTH);
      pop = run && mq.size() != 0 && m_rem <= 1;
      m_strobe = 1'b0;
      if (pop) begin
        {m_sel, m_word} = mq.pop_front();
        m_strobe = 1'b1;
        m_rem = HOLD;
      end else if (m_rem > 0) begin
        m_rem--;
      end
      if (in_valid && rdy) begin
        if (m_lane == 3)
          mq.push_back({in_sel, in_byte, m_part[2], m_part[1], m_part[0]});
        else
          m_part[m_lane] = in_byte;
        m_lane = (m_lane + 1) % 4;
      end
    end
  end

  logic [35:0] w [6];
  logic [35:0] c_word [8];
  int          c_time [8];
  int          c_n;
  int          c_maxcnt;

  task automatic apply_reset();
    @(negedge clk_in);
    rst_n = 1'b0;
    in_valid = 1'b0;
    run = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [3:0] s);
    int t;
    in_valid = 1'b1;
    in_byte = b;
    in_sel = s;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk_in);
      t++;
    end
    if (!in_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_byte: in_ready=%b required 1 within 200 cycles",
               in_ready);
    end else begin
      @(posedge clk_in);
      @(negedge clk_in);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [35:0] v);
    send_byte(v[7:0], 4'($urandom));
    send_byte(v[15:8], 4'($urandom));
    send_byte(v[23:16], 4'($urandom));
    send_byte(v[31:24], v[35:32]);
  endtask

  task automatic gen_words();
    for (int i = 0; i < 6; i++)
      w[i] = {4'($urandom), 32'($urandom)};
  endtask

  task automatic collect(input int n, input int bound);
    c_n = 0;
    c_maxcnt = 0;
    for (int t = 0; t < bound && c_n < n; t++) begin
      @(negedge clk_in);
      if (int'(fifo_count) > c_maxcnt) c_maxcnt = int'(fifo_count);
      if (word_strobe) begin
        c_word[c_n] = {path_sel_out, word_out};
        c_time[c_n] = t;
        c_n++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_byte = 8'h5A;
    run = 1'b1;
    repeat (3) @(negedge clk_in);
    n_vec++;
    if ({word_out, path_sel_out} !== 36'h0) begin
      n_bad++;
      $display("FAIL reset_word: got %h required 0", {path_sel_out, word_out});
    end
    n_vec++;
    if ({word_strobe, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_flags: strobe/busy=%b required 00",
               {word_strobe, busy});
    end
    n_vec++;
    if (fifo_count !== 3'd0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_fifo: count=%0d ready=%b required 0/1",
               fifo_count, in_ready);
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    run = 1'b0;
    @(negedge clk_in);
    n_vec++;
    if (word_strobe !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_after_strobe: got %b required 0", word_strobe);
    end
  endtask

  task automatic test_basic();
    int busy_n;
    int strobes;
    apply_reset();
    run = 1'b1;
    send_word({4'b0101, 32'h40302010});
    n_vec++;
    if (fifo_count !== 3'd1 || word_strobe !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_pushed: count=%0d strobe=%b required 1/0",
               fifo_count, word_strobe);
    end
    @(negedge clk_in);
    n_vec++;
    if ({path_sel_out, word_out} !== {4'b0101, 32'h40302010}) begin
      n_bad++;
      $display("FAIL basic_word: got %h required 540302010",
               {path_sel_out, word_out});
    end
    n_vec++;
    if ({word_strobe, busy} !== 2'b11 || fifo_count !== 3'd0) begin
      n_bad++;
      $display("FAIL basic_pop: strobe/busy=%b count=%0d required 11/0",
               {word_strobe, busy}, fifo_count);
    end
    busy_n = 1;
    strobes = 0;
    for (int i = 0; i < HOLD + 4; i++) begin
      @(negedge clk_in);
      if (busy) busy_n++;
      if (word_strobe) strobes++;
    end
    n_vec++;
    if (busy_n != HOLD || strobes != 0) begin
      n_bad++;
      $display("FAIL basic_hold: busy=%0d extra strobes=%0d required %0d/0",
               busy_n, strobes, HOLD);
    end
    n_vec++;
    if (word_out !== 32'h40302010 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_retain: word=%h busy=%b required 40302010/0",
               word_out, busy);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    gen_words();
    run = 1'b1;
    fork
      begin
        for (int i = 0; i < 3; i++) send_word(w[i]);
      end
      collect(3, 60);
    join
    n_vec++;
    if (c_n != 3) begin
      n_bad++;
      $display("FAIL b2b_count: strobes=%0d required 3", c_n);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (c_word[i] !== w[i]) begin
          n_bad++;
          $display("FAIL b2b_word%0d: got %h required %h", i, c_word[i], w[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        n_vec++;
        if (c_time[i] - c_time[i-1] != HOLD) begin
          n_bad++;
          $display("FAIL b2b_gap%0d: got %0d required %0d",
                   i, c_time[i] - c_time[i-1], HOLD);
        end
      end
    end
    n_vec++;
    if (c_maxcnt > 2) begin
      n_bad++;
      $display("FAIL b2b_maxcount: got %0d required <=2", c_maxcnt);
    end
  endtask

  task automatic test_full();
    apply_reset();
    gen_words();
    for (int i = 0; i < 4; i++) send_word(w[i]);
    n_vec++;
    if (fifo_count !== 3'd4) begin
      n_bad++;
      $display("FAIL full_count: got %0d required 4", fifo_count);
    end
    for (int l = 0; l < 3; l++) begin
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL full_lane%0d_ready: got %b required 1", l, in_ready);
      end
      send_byte(w[4][l*8 +: 8], 4'($urandom));
    end
    in_valid = 1'b1;
    in_byte = w[4][31:24];
    in_sel = w[4][35:32];
    repeat (3) @(negedge clk_in);
    n_vec++;
    if (in_ready !== 1'b0 || fifo_count !== 3'd4) begin
      n_bad++;
      $display("FAIL full_lane3_blocked: ready=%b count=%0d required 0/4",
               in_ready, fifo_count);
    end
    run = 1'b1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL full_pop_cycle_ready: got %b required 0", in_ready);
    end
    @(negedge clk_in);
    n_vec++;
    if (word_strobe !== 1'b1 || {path_sel_out, word_out} !== w[0]) begin
      n_bad++;
      $display("FAIL full_first_pop: strobe=%b word=%h required 1/%h",
               word_strobe, {path_sel_out, word_out}, w[0]);
    end
    n_vec++;
    if (in_ready !== 1'b1 || fifo_count !== 3'd3) begin
      n_bad++;
      $display("FAIL full_after_pop: ready=%b count=%0d required 1/3",
               in_ready, fifo_count);
    end
    @(negedge clk_in);
    in_valid = 1'b0;
    n_vec++;
    if (fifo_count !== 3'd4) begin
      n_bad++;
      $display("FAIL full_word5_push: count=%0d required 4", fifo_count);
    end
    collect(4, 5 * HOLD + 10);
    n_vec++;
    if (c_n != 4) begin
      n_bad++;
      $display("FAIL full_drain: strobes=%0d required 4", c_n);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (c_word[i] !== w[i+1]) begin
          n_bad++;
          $display("FAIL full_word%0d: got %h required %h",
                   i + 1, c_word[i], w[i+1]);
        end
      end
      n_vec++;
      if (c_time[0] != HOLD - 2 || c_time[3] - c_time[0] != 3 * HOLD) begin
        n_bad++;
        $display("FAIL full_spacing: first=%0d span=%0d required %0d/%0d",
                 c_time[0], c_time[3] - c_time[0], HOLD - 2, 3 * HOLD);
      end
    end
  endtask

  task automatic test_same_cycle();
    apply_reset();
    gen_words();
    for (int i = 0; i < 3; i++) send_word(w[i]);
    for (int l = 0; l < 3; l++) send_byte(w[3][l*8 +: 8], 4'($urandom));
    in_valid = 1'b1;
    in_byte = w[3][31:24];
    in_sel = w[3][35:32];
    run = 1'b1;
    n_vec++;
    if (in_ready !== 1'b1 || fifo_count !== 3'd3) begin
      n_bad++;
      $display("FAIL same_pre: ready=%b count=%0d required 1/3",
               in_ready, fifo_count);
    end
    @(negedge clk_in);
    in_valid = 1'b0;
    n_vec++;
    if (word_strobe !== 1'b1 || {path_sel_out, word_out} !== w[0]
        || fifo_count !== 3'd3) begin
      n_bad++;
      $display("FAIL same_pushpop: strobe=%b word=%h count=%0d required 1/%h/3",
               word_strobe, {path_sel_out, word_out}, fifo_count, w[0]);
    end
    collect(3, 4 * HOLD + 10);
    n_vec++;
    if (c_n != 3) begin
      n_bad++;
      $display("FAIL same_drain: strobes=%0d required 3", c_n);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (c_word[i] !== w[i+1]) begin
          n_bad++;
          $display("FAIL same_word%0d: got %h required %h",
                   i + 1, c_word[i], w[i+1]);
        end
      end
      n_vec++;
      if (c_time[0] != HOLD - 1 || c_time[2] - c_time[1] != HOLD) begin
        n_bad++;
        $display("FAIL same_spacing: first=%0d gap=%0d required %0d/%0d",
                 c_time[0], c_time[2] - c_time[1], HOLD - 1, HOLD);
      end
    end
  endtask

  task automatic test_run_stop();
    int busy_n;
    int extra;
    bit moved;
    apply_reset();
    gen_words();
    send_word(w[0]);
    send_word(w[1]);
    run = 1'b1;
    @(negedge clk_in);
    run = 1'b0;
    n_vec++;
    if (word_strobe !== 1'b1 || {path_sel_out, word_out} !== w[0]) begin
      n_bad++;
      $display("FAIL stop_first: strobe=%b word=%h required 1/%h",
               word_strobe, {path_sel_out, word_out}, w[0]);
    end
    busy_n = 1;
    extra = 0;
    moved = 1'b0;
    for (int i = 0; i < 3 * HOLD; i++) begin
      @(negedge clk_in);
      if (busy) busy_n++;
      if (word_strobe) extra++;
      if ({path_sel_out, word_out} !== w[0]) moved = 1'b1;
    end
    n_vec++;
    if (busy_n != HOLD || extra != 0 || moved) begin
      n_bad++;
      $display("FAIL stop_hold: busy=%0d strobes=%0d moved=%b required %0d/0/0",
               busy_n, extra, moved, HOLD);
    end
    n_vec++;
    if (fifo_count !== 3'd1) begin
      n_bad++;
      $display("FAIL stop_count: got %0d required 1", fifo_count);
    end
    run = 1'b1;
    @(negedge clk_in);
    n_vec++;
    if (word_strobe !== 1'b1 || {path_sel_out, word_out} !== w[1]) begin
      n_bad++;
      $display("FAIL stop_resume: strobe=%b word=%h required 1/%h",
               word_strobe, {path_sel_out, word_out}, w[1]);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    gen_words();
    for (int i = 0; i < 3; i++) send_word(w[i]);
    run = 1'b1;
    @(negedge clk_in);
    run = 1'b0;
    send_byte(w[3][7:0], 4'h0);
    send_byte(w[3][15:8], 4'h0);
    n_vec++;
    if (fifo_count !== 3'd2 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_pre: count=%0d busy=%b required 2/1",
               fifo_count, busy);
    end
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_byte = 8'hEE;
    run = 1'b1;
    @(negedge clk_in);
    n_vec++;
    if ({path_sel_out, word_out} !== 36'h0 || {word_strobe, busy} !== 2'b00
        || fifo_count !== 3'd0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset: word=%h sb=%b count=%0d ready=%b required 0/00/0/1",
               {path_sel_out, word_out}, {word_strobe, busy},
               fifo_count, in_ready);
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk_in);
    n_vec++;
    if (word_strobe !== 1'b0 || fifo_count !== 3'd0) begin
      n_bad++;
      $display("FAIL mid_after: strobe=%b count=%0d required 0/0",
               word_strobe, fifo_count);
    end
    fork
      send_word({4'hA, 32'hDDCCBBAA});
      collect(1, 12);
    join
    n_vec++;
    if (c_n != 1 || c_word[0] !== {4'hA, 32'hDDCCBBAA}) begin
      n_bad++;
      $display("FAIL mid_fresh: strobes=%0d word=%h required 1/addccbbaa",
               c_n, c_word[0]);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk_in);
      n_vec++;
      if ({path_sel_out, word_out} !== {m_sel, m_word}) begin
        n_bad++;
        $display("FAIL rnd_word @%0d: got %h required %h",
                 i, {path_sel_out, word_out}, {m_sel, m_word});
      end
      n_vec++;
      if (word_strobe !== m_strobe || busy !== (m_rem > 0)) begin
        n_bad++;
        $display("FAIL rnd_flags @%0d: strobe/busy=%b required %b%b",
                 i, {word_strobe, busy}, m_strobe, m_rem > 0);
      end
      n_vec++;
      if (fifo_count !== 3'(mq.size())) begin
        n_bad++;
        $display("FAIL rnd_count @%0d: got %0d required %0d",
                 i, fifo_count, mq.size());
      end
      n_vec++;
      if (in_ready !== !(m_lane == 3 && mq.size() == DEPTH)) begin
        n_bad++;
        $display("FAIL rnd_ready @%0d: got %b required %b",
                 i, in_ready, !(m_lane == 3 && mq.size() == DEPTH));
      end
      rst_n = ($urandom_range(0, 149) != 0);
      if (i % 40 == 0) run = ($urandom_range(0, 2) != 0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_byte = 8'($urandom);
      in_sel = 4'($urandom);
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_full();
    test_same_cycle();
    test_run_stop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
